// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per clk. Optional parity bit: PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [CNT_W-1:0] cnt_inc;
  logic             at_last;
  logic             load_fire;

  // Bit that leaves the word next, and the word after that bit has left.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign at_last    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  // Ready on the last frame bit too, so back-to-back frames have no idle gap.
  assign load_ready = rst && ((state_q == IDLE) || at_last);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d      = parity_q;
`endif

    if (load_fire) begin
      // The first bit goes straight to the output register; the rest wait in shreg.
      state_d       = SHIFT;
      shreg_d       = advance(data_in);
      cnt_d         = '0;
      ser_out_d     = head_bit(data_in);
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_d      = ^data_in;
`endif
    end else if (state_q == SHIFT && !at_last) begin
      cnt_d       = cnt_inc;
      ser_valid_d = 1'b1;
      done_d      = (cnt_inc == LAST_IDX);
      shreg_d     = advance(shreg_q);
`ifdef PISO_SERIALIZER_PARITY_EN
      ser_out_d   = (cnt_inc == CNT_W'(WIDTH)) ? parity_q : head_bit(shreg_q);
`else
      ser_out_d   = head_bit(shreg_q);
`endif
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the data shift register is cleared on reset too, so no stale word survives an abort.
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share
// the same stimulus; expected frames come from a word-level reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic ready_m, so_m, sv_m, fs_m, dn_m;
  logic ready_l, so_l, sv_l, fs_l, dn_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .done(dn_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .done(dn_l)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  int   rem = 0;       // frame bits still to appear, counting the current cycle
  bit   started = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic even_parity(input logic [W-1:0] w);
    logic p = 1'b0;
    for (int i = 0; i < W; i++) p = p ^ w[i];
    return p;
  endfunction

  // A frame is the data bits in the configured order, then the parity bit if enabled.
  function automatic void push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int k = 0; k < FL; k++) begin
      e.fs = (k == 0);
      e.dn = (k == FL - 1);
      e.b  = (k < W) ? w[W-1-k] : even_parity(w);
      q_m.push_back(e);
      e.b  = (k < W) ? w[k] : even_parity(w);
      q_l.push_back(e);
    end
  endfunction

  // Reference model: accepts a word when idle or on the last bit of a frame.
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      rem = 0;
      q_m.delete();
      q_l.delete();
    end else if (load_valid && rem <= 1) begin
      rem = FL;
      push_frame(data_in);
    end else if (rem > 0) begin
      rem = rem - 1;
    end
  end

  task automatic chk_lane(input bit lane, input logic sv, input logic so,
                          input logic fs, input logic dn);
    exp_t  e;
    int    sz;
    string nm;
    nm = lane ? "lsb" : "msb";
    check({nm, "_ser_valid"}, 32'(sv), 32'(rem > 0));
    if (sv === 1'b1 && rem > 0) begin
      sz = lane ? q_l.size() : q_m.size();
      check({nm, "_sb_has_entry"}, 32'(sz > 0), 32'd1);
      if (sz > 0) begin
        e = lane ? q_l.pop_front() : q_m.pop_front();
        check({nm, "_ser_out"}, 32'(so), 32'(e.b));
        check({nm, "_frame_start"}, 32'(fs), 32'(e.fs));
        check({nm, "_done"}, 32'(dn), 32'(e.dn));
      end
    end else begin
      check({nm, "_idle_ser_out"}, 32'(so), 32'd0);
      check({nm, "_idle_frame_start"}, 32'(fs), 32'd0);
      check({nm, "_idle_done"}, 32'(dn), 32'd0);
    end
  endtask

  // Monitor: samples mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("msb_load_ready", 32'(ready_m), 32'(rst && rem <= 1));
      check("lsb_load_ready", 32'(ready_l), 32'(rst && rem <= 1));
      chk_lane(1'b0, sv_m, so_m, fs_m, dn_m);
      chk_lane(1'b1, sv_l, so_l, fs_l, dn_l);
    end
  end

  // Apply inputs just after a rising edge and hold them for n cycles.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input int n);
    rst        = r;
    load_valid = v;
    data_in    = d;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset with load_valid high, then idle.
    drive(1'b0, 1'b1, 4'b1010, 3);
    drive(1'b1, 1'b0, 4'b0000, 5);

    // Single word.
    drive(1'b1, 1'b1, 4'b1011, 1);
    drive(1'b1, 1'b0, 4'b0000, FL + 3);

    // Back-to-back: second word offered on the last-bit cycle.
    drive(1'b1, 1'b1, 4'b1100, FL);
    drive(1'b1, 1'b1, 4'b0011, 1);
    drive(1'b1, 1'b0, 4'b0000, FL + 3);

    // Busy: a word offered mid-frame must be dropped.
    drive(1'b1, 1'b1, 4'b1001, 1);
    drive(1'b1, 1'b0, 4'b0000, 1);
    drive(1'b1, 1'b1, 4'b1111, 2);
    drive(1'b1, 1'b0, 4'b0000, FL + 3);

    // Reset mid-frame, then a fresh word.
    drive(1'b1, 1'b1, 4'b1110, 1);
    drive(1'b1, 1'b0, 4'b0000, 1);
    drive(1'b0, 1'b0, 4'b0000, 1);
    drive(1'b1, 1'b0, 4'b0000, 2);
    drive(1'b1, 1'b1, 4'b0101, 1);
    drive(1'b1, 1'b0, 4'b0000, FL + 3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), W'($urandom), 1);
    end
    drive(1'b1, 1'b0, 4'b0000, FL + 3);

    check("msb_sb_drained", 32'(q_m.size()), 32'd0);
    check("lsb_sb_drained", 32'(q_l.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
